// File: rtl/clocked_reset_gen.sv
// Generated active-low DUT reset with hold/settle sequencing, run qualification and cycle count.
// Optional watchdog enabled by defining CLOCKED_RESET_GEN_WATCHDOG_EN.
module clocked_reset_gen #(
    parameter int HOLD_CYCLES    = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sw_rst,
    input  logic             i_done,
    output logic             o_rst,
    output logic             o_rst_fall,
    output logic             o_rst_rise,
    output logic             o_running,
    output logic [CNT_W-1:0] o_cycle,
    output logic             o_timeout
);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_SETTLE,
        ST_RUN,
`ifdef CLOCKED_RESET_GEN_WATCHDOG_EN
        ST_TIMEOUT,
`endif
        ST_DONE
    } state_e;

    localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    // Elaboration-time guard against illegal configurations.
    if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("clocked_reset_gen: HOLD_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e           state_q;
    logic [31:0]      hold_q;
    logic [31:0]      settle_q;
    logic             rst_q;
    logic             fall_q;
    logic             rise_q;
    logic             running_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] cycle_d;

    assign cycle_d = sat_inc(cycle_q);

`ifdef CLOCKED_RESET_GEN_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    logic timeout_q;
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_HOLD;
            hold_q    <= '0;
            settle_q  <= '0;
            rst_q     <= 1'b0;
            fall_q    <= 1'b0;
            rise_q    <= 1'b0;
            running_q <= 1'b0;
            cycle_q   <= '0;
`ifdef CLOCKED_RESET_GEN_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            fall_q <= 1'b0;
            rise_q <= 1'b0;
            // Soft reset outranks everything except an active hold, which it cannot restart.
            if (i_sw_rst && state_q != ST_HOLD) begin
                state_q   <= ST_HOLD;
                hold_q    <= '0;
                rst_q     <= 1'b0;
                fall_q    <= 1'b1;
                running_q <= 1'b0;
                cycle_q   <= '0;
`ifdef CLOCKED_RESET_GEN_WATCHDOG_EN
                timeout_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q   <= '0;
                            settle_q <= '0;
                            rst_q    <= 1'b1;
                            rise_q   <= 1'b1;
                            cycle_q  <= '0;
                            if (SETTLE_CYCLES == 0) begin
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                            end else begin
                                state_q <= ST_SETTLE;
                            end
                        end else begin
                            hold_q <= hold_q + 32'd1;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_q == SETTLE_LAST) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                            cycle_q   <= '0;
                        end else begin
                            settle_q <= settle_q + 32'd1;
                        end
                    end
                    ST_RUN: begin
                        cycle_q <= cycle_d;
                        if (i_done) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                        end
`ifdef CLOCKED_RESET_GEN_WATCHDOG_EN
                        else if (cycle_d == TIMEOUT_C) begin
                            state_q   <= ST_TIMEOUT;
                            running_q <= 1'b0;
                            timeout_q <= 1'b1;
                        end
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_rst      = rst_q;
    assign o_rst_fall = fall_q;
    assign o_rst_rise = rise_q;
    assign o_running  = running_q;
    assign o_cycle    = cycle_q;

endmodule

// File: tb/tb_clocked_reset_gen.sv
// Bench for clocked_reset_gen: table-driven scoreboard on the default instance plus
// hand sequences for SETTLE_CYCLES=0 / CNT_W=3 saturation and the watchdog instance.
module tb_clocked_reset_gen;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    logic sw, done;

    logic        r0, f0, u0, n0, t0;
    logic [31:0] cyc0;
    logic        r1, f1, u1, n1, t1;
    logic [2:0]  cyc1;
    logic        r2, f2, u2, n2, t2;
    logic [31:0] cyc2;

`ifdef CLOCKED_RESET_GEN_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    always #5 clk = ~clk;

    clocked_reset_gen dut0 (
        .i_clk(clk), .i_rst(rst0), .i_sw_rst(sw), .i_done(done),
        .o_rst(r0), .o_rst_fall(f0), .o_rst_rise(u0), .o_running(n0),
        .o_cycle(cyc0), .o_timeout(t0)
    );

    clocked_reset_gen #(.SETTLE_CYCLES(0), .CNT_W(3)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_sw_rst(sw), .i_done(done),
        .o_rst(r1), .o_rst_fall(f1), .o_rst_rise(u1), .o_running(n1),
        .o_cycle(cyc1), .o_timeout(t1)
    );

    clocked_reset_gen #(.TIMEOUT_CYCLES(5)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_sw_rst(sw), .i_done(done),
        .o_rst(r2), .o_rst_fall(f2), .o_rst_rise(u2), .o_running(n2),
        .o_cycle(cyc2), .o_timeout(t2)
    );

    wire [4:0] ctl0 = {r0, f0, u0, n0, t0};
    wire [4:0] ctl1 = {r1, f1, u1, n1, t1};
    wire [4:0] ctl2 = {r2, f2, u2, n2, t2};

    typedef struct {
        logic        sw;
        logic        done;
        logic [4:0]  ctl;
        logic [31:0] cyc;
    } vec_t;

    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t e;
    int   vi = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic void add(input logic s, input logic d, input logic [4:0] c, input int cy);
        vec_t v;
        v.sw   = s;
        v.done = d;
        v.ctl  = c;
        v.cyc  = 32'(cy);
        vecs.push_back(v);
    endfunction

    // ctl bit order: {o_rst, o_rst_fall, o_rst_rise, o_running, o_timeout}
    function automatic void add_restart();
        for (int k = 0; k < 3; k++) add(0, 0, 5'b00000, 0);
        add(0, 0, 5'b10100, 0);
        add(0, 0, 5'b10000, 0);
        add(0, 0, 5'b10010, 0);
    endfunction

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("vec%0d_ctl", vi), {27'd0, ctl0}, {27'd0, e.ctl});
            chk($sformatf("vec%0d_cycle", vi), cyc0, e.cyc);
            vi++;
        end
    end

    task automatic step(input int sel, input logic s, input logic d,
                        input logic [4:0] c, input logic [31:0] cy, input string nm);
        sw   = s;
        done = d;
        @(posedge clk);
        #1;
        case (sel)
            1: begin
                chk({nm, "_ctl"}, {27'd0, ctl1}, {27'd0, c});
                chk({nm, "_cycle"}, {29'd0, cyc1}, cy);
            end
            default: begin
                chk({nm, "_ctl"}, {27'd0, ctl2}, {27'd0, c});
                chk({nm, "_cycle"}, cyc2, cy);
            end
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        sw = 1'b0; done = 1'b0;
        #1;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        #2;
        chk("reset_ctl0", {27'd0, ctl0}, 32'd0);
        chk("reset_cyc0", cyc0, 32'd0);
        chk("reset_ctl1", {27'd0, ctl1}, 32'd0);
        chk("reset_ctl2", {27'd0, ctl2}, 32'd0);

        // Default instance vector table.
        add(0, 0, 5'b00000, 0);
        add(0, 0, 5'b00000, 0);
        add(1, 0, 5'b00000, 0);           // soft reset in HOLD ignored
        add(1, 0, 5'b10100, 0);           // soft reset on rise edge deferred
        add(0, 0, 5'b10000, 0);
        add(0, 0, 5'b10010, 0);
        for (int k = 1; k <= 10; k++) add(0, 0, 5'b10010, k);
        add(0, 1, 5'b10000, 11);          // done: frozen including done edge
        add(0, 0, 5'b10000, 11);
        add(0, 1, 5'b10000, 11);          // done outside RUN ignored
        add(1, 0, 5'b01000, 0);           // soft reset from DONE
        add_restart();
        for (int k = 1; k <= 5; k++) add(0, 0, 5'b10010, k);
        add(1, 0, 5'b01000, 0);           // soft reset at cycle 5
        add_restart();
        add(0, 0, 5'b10010, 1);
        add(1, 1, 5'b01000, 0);           // soft reset beats done
        for (int k = 0; k < 3; k++) add(0, 0, 5'b00000, 0);
        add(0, 0, 5'b10100, 0);
        add(1, 0, 5'b01000, 0);           // soft reset from SETTLE
        add_restart();
        add(0, 0, 5'b10010, 1);

        @(negedge clk);
        rst0 = 1'b1;
        foreach (vecs[i]) begin
            exp_t x;
            sw   = vecs[i].sw;
            done = vecs[i].done;
            x.ctl = vecs[i].ctl;
            x.cyc = vecs[i].cyc;
            sb.push_back(x);
            @(negedge clk);
        end
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("vectors_compared", vi, vecs.size());

        // Async reset mid-run: immediate reset values, no fall strobe.
        #2;
        rst0 = 1'b0;
        #1;
        chk("async_midrun_ctl0", {27'd0, ctl0}, 32'd0);
        chk("async_midrun_cyc0", cyc0, 32'd0);

        // SETTLE_CYCLES=0, CNT_W=3: run starts with rise, cycle saturates at 7.
        sw = 1'b0; done = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        for (int k = 1; k <= 3; k++) step(1, 0, 0, 5'b00000, 0, $sformatf("s0_hold%0d", k));
        step(1, 0, 0, 5'b10110, 0, "s0_rise_run");
        for (int k = 5; k <= 14; k++)
            step(1, 0, 0, 5'b10010, (k - 4 > 7) ? 7 : k - 4, $sformatf("s0_run%0d", k));
        rst1 = 1'b0;

        // TIMEOUT_CYCLES=5: watchdog when compiled in, plain counting otherwise.
        @(negedge clk);
        rst2 = 1'b1;
        for (int k = 1; k <= 3; k++) step(2, 0, 0, 5'b00000, 0, $sformatf("wd_hold%0d", k));
        step(2, 0, 0, 5'b10100, 0, "wd_rise");
        step(2, 0, 0, 5'b10000, 0, "wd_settle");
        step(2, 0, 0, 5'b10010, 0, "wd_run0");
        for (int k = 1; k <= 4; k++) step(2, 0, 0, 5'b10010, k, $sformatf("wd_run%0d", k));
        step(2, 0, 0, WD ? 5'b10001 : 5'b10010, 5, "wd_hit");
        step(2, 0, 0, WD ? 5'b10001 : 5'b10010, WD ? 5 : 6, "wd_sticky1");
        step(2, 0, 0, WD ? 5'b10001 : 5'b10010, WD ? 5 : 7, "wd_sticky2");
        step(2, 1, 0, 5'b01000, 0, "wd_swrst_clear");
        for (int k = 1; k <= 3; k++) step(2, 0, 0, 5'b00000, 0, $sformatf("wd2_hold%0d", k));
        step(2, 0, 0, 5'b10100, 0, "wd2_rise");
        step(2, 0, 0, 5'b10000, 0, "wd2_settle");
        step(2, 0, 0, 5'b10010, 0, "wd2_run0");
        for (int k = 1; k <= 4; k++) step(2, 0, 0, 5'b10010, k, $sformatf("wd2_run%0d", k));
        step(2, 0, 1, 5'b10000, 5, "wd2_done_wins");
        step(2, 0, 0, 5'b10000, 5, "wd2_done_hold");
        rst2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clocked_reset_gen.md
Name: clocked_reset_gen

Overview:
- Drives the DUT-side active-low reset and run qualification for a Nicotb bench; it generates reset rather than observing it.
- Holds the DUT reset low for a fixed cycle count after bench reset or a testbench soft-reset request, then releases it and waits a settle window.
- Then qualifies a run window and counts run cycles until the bench signals done.
- Emits single-cycle reset-fall/reset-rise strobes so bench-side event hooks can align to the generated reset.

Parameters:
- HOLD_CYCLES, 4, clock edges o_rst stays low after reset release or soft-reset request; legal range >= 1.
- SETTLE_CYCLES, 2, edges between o_rst rising and o_running asserting; 0 means enter RUN directly.
- CNT_W, 32, width of the run-cycle counter.
- TIMEOUT_CYCLES, 1000, watchdog limit in RUN cycles; used only with the optional feature; must be >= 1.

Ports:
- i_clk  input  1  bench clock; all state updates on posedge.
- i_rst  input  1  asynchronous active-low reset.
- i_sw_rst  input  1  soft-reset request, sampled on posedge.
- i_done  input  1  bench completion indication, sampled on posedge.
- o_rst  output  1  generated DUT reset, active-low, registered.
- o_rst_fall  output  1  one-cycle strobe: o_rst just went low from soft reset.
- o_rst_rise  output  1  one-cycle strobe: o_rst just went high.
- o_running  output  1  high while in RUN.
- o_cycle  output  CNT_W  RUN cycle count.
- o_timeout  output  1  sticky watchdog flag.

Behaviour:
- Async reset (i_rst=0):
  - state=HOLD, hold counter=0, settle counter=0.
  - o_rst=0, o_rst_fall=0, o_rst_rise=0, o_running=0, o_cycle=0, o_timeout=0.
- States: HOLD, SETTLE, RUN, DONE, TIMEOUT. All outputs are registered; no combinational paths from inputs to outputs.
- HOLD:
  - o_rst=0. The hold counter increments each edge.
  - On the HOLD_CYCLES-th edge in HOLD: go to SETTLE (or RUN if SETTLE_CYCLES=0), set o_rst=1, pulse o_rst_rise=1 for exactly that cycle.
  - Result: o_rst is low for exactly HOLD_CYCLES rising edges after i_rst deasserts.
  - i_sw_rst in HOLD is ignored; the counter does not restart.
- SETTLE:
  - o_rst=1, o_running=0.
  - After SETTLE_CYCLES edges: go to RUN, set o_running=1.
- RUN:
  - o_running=1.
  - o_cycle increments by 1 per edge and saturates at 2^CNT_W-1 (no wrap).
  - The first RUN cycle shows o_cycle=0.
- i_done=1 sampled in RUN:
  - Go to DONE; o_running=0 on the next cycle.
  - o_cycle freezes at its value, which includes the done edge's increment.
- i_done outside RUN: ignored.
- i_sw_rst=1 sampled in SETTLE, RUN, DONE or TIMEOUT:
  - Next cycle: state=HOLD, o_rst=0, o_rst_fall=1 for one cycle, o_running=0, o_cycle=0, o_timeout=0, hold counter=0.
  - o_rst then stays low for HOLD_CYCLES further edges.
- i_sw_rst and i_done sampled on the same edge in RUN: soft reset wins.
- A soft reset requested in the same edge that o_rst_rise pulses is deferred. That edge's state is still HOLD, so the request is ignored.
- Async reset asserted mid-run: all outputs immediately take their reset values; no o_rst_fall pulse.
- o_rst_fall and o_rst_rise are never high in the same cycle.

Optional Feature:
- Macro: CLOCKED_RESET_GEN_WATCHDOG_EN.
- Defined:
  - In RUN, if the edge would make o_cycle equal TIMEOUT_CYCLES and i_done=0: go to TIMEOUT, o_running=0, o_timeout=1 (sticky).
  - o_timeout clears only on async reset or soft reset.
  - If i_done=1 on that same edge: DONE wins and o_timeout stays 0.
  - If i_sw_rst=1 on that same edge: soft reset wins.
- Not defined: TIMEOUT state and compare logic are absent; o_timeout is tied 0; TIMEOUT_CYCLES is unused.

Test Plan:
- Power-on, default parameters: release i_rst at edge 0 -> o_rst low through edge 4, high after edge 4 with o_rst_rise pulsed 1 cycle; o_running high after edge 6; o_cycle=0 in the first RUN cycle.
- Run 10 cycles, then i_done=1 for 1 cycle -> o_running=0 next cycle; o_cycle frozen at 11; further edges do not change it.
- i_sw_rst pulse in RUN at o_cycle=5 -> next cycle o_rst=0, o_rst_fall=1 for 1 cycle, o_cycle=0; o_rst high again 4 edges later with o_rst_rise.
- i_sw_rst and i_done on the same edge in RUN -> HOLD entered, o_rst_fall=1, no DONE; i_sw_rst during HOLD -> no counter restart.
- SETTLE_CYCLES=0, CNT_W=3 -> o_running asserts in the same cycle as o_rst_rise; o_cycle saturates at 7 after 8+ RUN edges.
- With CLOCKED_RESET_GEN_WATCHDOG_EN, TIMEOUT_CYCLES=5, no i_done -> o_timeout=1 sticky after the 5th RUN edge and o_running=0; i_sw_rst clears it. Without the macro, the same stimulus gives o_timeout=0 and o_cycle keeps counting.
